// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative signed multiply/divide unit:
// FSM state encoding, default operand width and last iteration index.
package mult_div_unit_pkg;
  localparam int WIDTH     = 32;
  localparam int ITER_LAST = WIDTH - 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MULT_RUN = 2'd1;
  localparam logic [1:0] S_DIV_RUN  = 2'd2;
  localparam logic [1:0] S_FINISH   = 2'd3;
endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit side bundle of the multiply/divide unit: start pulses,
// operands, HI/LO results and status flags.
interface mult_div_if #(parameter int WIDTH = 32) ();
  logic             initMult;
  logic             initDiv;
  logic [WIDTH-1:0] Avalue;
  logic [WIDTH-1:0] Bvalue;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (output initMult, initDiv, Avalue, Bvalue,
                  input  HI, LO, busy, done, divByZero);
  modport slave  (input  initMult, initDiv, Avalue, Bvalue,
                  output HI, LO, busy, done, divByZero);
endinterface

// File: rtl/mult_div_unit_step.sv
// One iteration of the shared datapath: a radix-2 Booth step (multiply)
// or a restoring shift/subtract step on magnitudes (divide).
module mult_div_step #(
  parameter int WIDTH = mult_div_unit_pkg::WIDTH
) (
  input  logic             i_is_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rsh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum  = i_acc;
    w_rsh  = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
    w_diff = w_rsh - i_m;
    o_acc  = i_acc;
    o_q    = i_q;
    o_q_1  = i_q_1;
    if (i_is_div) begin
      // Remainder stays below the divisor, so the top bit of the
      // difference is a reliable borrow flag.
      if (!w_diff[WIDTH]) begin
        o_acc = w_diff;
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_rsh;
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      case ({i_q[0], i_q_1})
        2'b01:   w_sum = i_acc + i_m;
        2'b10:   w_sum = i_acc - i_m;
        default: w_sum = i_acc;
      endcase
      {o_acc, o_q, o_q_1} = {w_sum[WIDTH], w_sum, i_q};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine owning HI/LO; one operand bit
// per clock, results loaded when leaving FINISH.
module mult_div_unit #(
  parameter int WIDTH = mult_div_unit_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  mult_div_if.slave bus
);
  import mult_div_unit_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div, r_sa, r_sb;
  logic [WIDTH:0]   r_acc, r_m;
  logic [WIDTH-1:0] r_q, r_hi, r_lo;
  logic             r_q_1, r_busy, r_done, r_dbz;

  logic [WIDTH:0]   w_acc_n;
  logic [WIDTH-1:0] w_q_n, w_a_mag, w_b_mag, w_quo, w_rem;
  logic             w_q1_n;

  assign w_a_mag = bus.Avalue[WIDTH-1] ? -bus.Avalue : bus.Avalue;
  assign w_b_mag = bus.Bvalue[WIDTH-1] ? -bus.Bvalue : bus.Bvalue;
  // Remainder follows the dividend sign; quotient negative on sign mismatch.
  assign w_quo = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rem = r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_q_1    (r_q_1),
    .i_m      (r_m),
    .o_acc    (w_acc_n),
    .o_q      (w_q_n),
    .o_q_1    (w_q1_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_q_1    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.initMult) begin
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_q      <= bus.Bvalue;
            r_q_1    <= 1'b0;
            r_m      <= {bus.Avalue[WIDTH-1], bus.Avalue};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MULT_RUN;
          end else if (bus.initDiv) begin
            if (bus.Bvalue != '0) begin
              r_is_div <= 1'b1;
              r_acc    <= '0;
              r_q      <= w_a_mag;
              r_q_1    <= 1'b0;
              r_m      <= {1'b0, w_b_mag};
              r_sa     <= bus.Avalue[WIDTH-1];
              r_sb     <= bus.Bvalue[WIDTH-1];
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_DIV_RUN;
            end else begin
              r_dbz <= 1'b1;
            end
          end
        end
        S_MULT_RUN, S_DIV_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_q_1 <= w_q1_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IT) r_state <= S_FINISH;
        end
        default: begin
          r_hi    <= r_is_div ? w_rem : r_acc[WIDTH-1:0];
          r_lo    <= r_is_div ? w_quo : r_q;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.divByZero = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products/quotients,
// divide-by-zero, overflow, start priority and asynchronous reset abort.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an operation, wait for done (bounded), check busy length and result.
  task automatic run(input string tag, input logic m, input logic d,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int bcnt;
    int cyc;
    @(negedge clk);
    bus.initMult = m; bus.initDiv = d; bus.Avalue = a; bus.Bvalue = b;
    @(negedge clk);
    bus.initMult = 1'b0; bus.initDiv = 1'b0;
    bcnt = 0; cyc = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) bcnt++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'd33);
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " HI"}, bus.HI, ehi);
    chk({tag, " LO"}, bus.LO, elo);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dcnt;
    tests = 0; fails = 0;
    reset = 1'b1;
    bus.initMult = 1'b0; bus.initDiv = 1'b0;
    bus.Avalue = '0; bus.Bvalue = '0;
    #12;
    chk("rst HI", bus.HI, 32'd0);
    chk("rst LO", bus.LO, 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst dbz", 32'(bus.divByZero), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mul maxpos", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run("mul minneg", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run("both", 1'b1, 1'b1, 32'd6, 32'd5, 32'd0, 32'd30);
    // Preload HI=0x11, LO=0x22 (629 = 34*18 + 17).
    run("preload", 1'b0, 1'b1, 32'd629, 32'd18, 32'h11, 32'h22);

    @(negedge clk);
    bus.initDiv = 1'b1; bus.Avalue = 32'd100; bus.Bvalue = 32'd0;
    @(negedge clk);
    bus.initDiv = 1'b0;
    chk("dbz pulse", 32'(bus.divByZero), 32'd1);
    chk("dbz busy", 32'(bus.busy), 32'd0);
    chk("dbz done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("dbz clear", 32'(bus.divByZero), 32'd0);
    chk("dbz busy2", 32'(bus.busy), 32'd0);
    chk("dbz HI", bus.HI, 32'h11);
    chk("dbz LO", bus.LO, 32'h22);

    @(negedge clk);
    bus.initMult = 1'b1; bus.Avalue = 32'd7; bus.Bvalue = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.initMult = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-rst busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst HI", bus.HI, 32'd0);
    chk("arst LO", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("arst no_done", 32'(dcnt), 32'd0);

    run("div 20/3", 1'b0, 1'b1, 32'd20, 32'd3, 32'd2, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
